// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC register, debug-loadable instruction memory,
// next-PC selection and the IF/ID pipeline register with stall, flush and HALT handling.
module instruction_fetch #(
  parameter int unsigned    NB_REG      = 32,
  parameter int unsigned    NB_MEM_ADDR = 8,
  parameter logic [NB_REG-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_dunit_clk_en,
  input  logic                   i_stall,
  input  logic                   i_PCSrc,
  input  logic [NB_REG-1:0]      i_branch_target,
  input  logic                   i_jump,
  input  logic [NB_REG-1:0]      i_jump_target,
  input  logic                   i_jr,
  input  logic [NB_REG-1:0]      i_jr_target,
  input  logic                   i_load_en,
  input  logic [NB_MEM_ADDR-1:0] i_load_addr,
  input  logic [NB_REG-1:0]      i_load_data,
  output logic [NB_REG-1:0]      o_instruction,
  output logic [NB_REG-1:0]      o_pcplus4,
  output logic [NB_REG-1:0]      o_pc,
  output logic                   o_halt
);

  localparam int unsigned Depth = 2 ** NB_MEM_ADDR;

  logic [NB_REG-1:0] imem [Depth];

  logic [NB_REG-1:0] pc_q, pc_d;
  logic [NB_REG-1:0] instr_q, instr_d;
  logic [NB_REG-1:0] pcplus4_q, pcplus4_d;
  logic              halt_q, halt_d;

  logic [NB_REG-1:0] fetch_word;
  logic [NB_REG-1:0] pc_plus4;
  logic              redirect;

  // Loads are a debug path and ignore pipeline enable, stall and halt.
  always_ff @(posedge i_clk) begin
    if (i_load_en) begin
      imem[i_load_addr] <= i_load_data;
    end
  end

  // Byte offset and PC bits above the memory depth are ignored, so fetch wraps.
  assign fetch_word = imem[pc_q[NB_MEM_ADDR+1:2]];
  assign pc_plus4   = pc_q + NB_REG'(4);
  assign redirect   = i_PCSrc | i_jump | i_jr;

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    halt_d    = halt_q;
    if (halt_q || i_stall) begin
      // Stall beats redirect; decode is held so the redirect reappears.
    end else if (redirect) begin
      instr_d   = '0;
      pcplus4_d = '0;
      if (i_PCSrc) begin
        pc_d = i_branch_target;
      end else if (i_jump) begin
        pc_d = i_jump_target;
      end else begin
        pc_d = i_jr_target;
      end
    end else if (fetch_word == HALT_WORD) begin
      instr_d   = HALT_WORD;
      pcplus4_d = pc_plus4;
      halt_d    = 1'b1;
    end else begin
      instr_d   = fetch_word;
      pcplus4_d = pc_plus4;
      pc_d      = pc_plus4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q      <= '0;
      instr_q   <= '0;
      pcplus4_q <= '0;
      halt_q    <= 1'b0;
    end else if (i_dunit_clk_en) begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      halt_q    <= halt_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_pcplus4     = pcplus4_q;
  assign o_halt        = halt_q;

endmodule
